// File: rtl/crypt_pkg.sv
// crypt_pkg: shared lane/key types, key constants and skid-stage occupancy encoding
package crypt_pkg;
    localparam int BYTE_W = 8;
    typedef logic [BYTE_W-1:0] lane_t;
    typedef logic [1:0] key2_t;
    localparam key2_t KEY_00 = 2'b00;
    localparam key2_t KEY_01 = 2'b01;
    localparam key2_t KEY_10 = 2'b10;
    localparam key2_t KEY_11 = 2'b11;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} stg_occ_e;
endpackage

// File: rtl/stage3_inv_perm.sv
// stage3_inv_perm: combinational inverse of the key-selected 4-lane byte shuffle
module stage3_inv_perm
    import crypt_pkg::*;
#(
    parameter int BYTE_W = 8
) (
    input  logic [4*BYTE_W-1:0] in_data,
    input  key2_t               key,
    output logic [4*BYTE_W-1:0] out_data
);
    logic [BYTE_W-1:0] i0, i1, i2, i3;
    assign {i3, i2, i1, i0} = in_data;
    // packed as {o3,o2,o1,o0}
    always_comb
        out_data = key == KEY_00 ? {i2, i3, i0, i1} :
                   key == KEY_01 ? {i3, i1, i2, i0} :
                   key == KEY_10 ? {i0, i2, i1, i3} :
                                   {i1, i2, i3, i0};
endmodule

// File: rtl/stage3_inv_pipe.sv
// stage3_inv_pipe: elastic stage undoing the stage-3 byte permutation, with a 2-entry skid buffer
module stage3_inv_pipe
    import crypt_pkg::*;
#(
    parameter int BYTE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*BYTE_W-1:0] in_data,
    input  logic [1:0]          in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*BYTE_W-1:0] out_data,
    output logic [1:0]          out_key
);
    localparam int W = 4*BYTE_W;
    stg_occ_e state_q, state_d;
    logic [W-1:0] perm_data, main_data, skid_data;
    key2_t main_key, skid_key;
    logic in_ready_q, accept, pop;

    stage3_inv_perm #(.BYTE_W(BYTE_W)) u_perm (
        .in_data (in_data),
        .key     (in_key),
        .out_data(perm_data)
    );

    assign accept = in_valid & in_ready_q;
    assign pop = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= state_d != TWO;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   state_d = accept ? ONE : EMPTY;
            ONE:     state_d = accept && !pop ? TWO : (pop && !accept ? EMPTY : ONE);
            TWO:     state_d = pop ? ONE : TWO;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = state_q != EMPTY;
        in_ready  = in_ready_q;
        out_data  = main_data;
        out_key   = main_key;
    end

    // data is stored already inverted, so the skid path needs no mux on the output side
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_data <= '0;
            main_key  <= '0;
            skid_data <= '0;
            skid_key  <= '0;
        end else begin
            if (state_q == TWO && pop) begin
                main_data <= skid_data;
                main_key  <= skid_key;
            end else if (accept && (state_q == EMPTY || pop)) begin
                main_data <= perm_data;
                main_key  <= in_key;
            end
            if (accept && !pop && state_q == ONE) begin
                skid_data <= perm_data;
                skid_key  <= in_key;
            end
        end
    end
endmodule

// File: tb/tb_stage3_inv_pipe.sv
// tb_stage3_inv_pipe: directed checks of the inverse permutation stage and its skid buffering
module tb_stage3_inv_pipe;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [1:0]  in_key = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  out_key;
    int n_cmp = 0;
    int n_err = 0;

    stage3_inv_pipe #(.BYTE_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_key   (in_key),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_key  (out_key)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // forward (encrypt-side) shuffle: lane n of the word lands in lane p(n)
    function automatic logic [31:0] enc(input logic [31:0] w, input logic [1:0] k);
        logic [7:0] w0, w1, w2, w3;
        {w3, w2, w1, w0} = w;
        case (k)
            2'b00:   return {w2, w3, w0, w1};
            2'b01:   return {w3, w1, w2, w0};
            2'b10:   return {w0, w2, w1, w3};
            default: return {w1, w2, w3, w0};
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp += 4;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0", out_data); end
        if (out_key !== 2'b00) begin n_err++; $display("FAIL reset_out_key got %b want 00", out_key); end
    endtask

    task automatic test_key_map();
        logic [1:0]  keys [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
        logic [31:0] exps [4] = '{32'h33441122, 32'h11332244, 32'h44223311, 32'h22334411};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = 32'h44332211;
            in_key = keys[i];
            tick();
            in_valid = 1'b0;
            n_cmp += 3;
            if (out_valid !== 1'b1) begin n_err++; $display("FAIL keymap_valid[%0d] got %b want 1", i, out_valid); end
            if (out_data !== exps[i]) begin n_err++; $display("FAIL keymap_data[%0d] got %h want %h", i, out_data, exps[i]); end
            if (out_key !== keys[i]) begin n_err++; $display("FAIL keymap_key[%0d] got %b want %b", i, out_key, keys[i]); end
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL keymap_drain got %b want 0", out_valid); end
    endtask

    task automatic test_round_trip();
        logic [31:0] w;
        logic [1:0]  k;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            k = 2'($urandom_range(3));
            in_valid = 1'b1;
            in_data = enc(w, k);
            in_key = k;
            tick();
            in_valid = 1'b0;
            n_cmp += 2;
            if (out_data !== w) begin n_err++; $display("FAIL roundtrip_data[%0d] got %h want %h", i, out_data, w); end
            if (out_key !== k) begin n_err++; $display("FAIL roundtrip_key[%0d] got %b want %b", i, out_key, k); end
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] w [3] = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
        logic [1:0]  k [3] = '{2'b01, 2'b10, 2'b11};
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = enc(w[0], k[0]);
        in_key = k[0];
        tick();
        n_cmp += 3;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid1 got %b want 1", out_valid); end
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1 got %b want 1", in_ready); end
        if (out_data !== w[0]) begin n_err++; $display("FAIL bp_data1 got %h want %h", out_data, w[0]); end
        in_data = enc(w[1], k[1]);
        in_key = k[1];
        tick();
        n_cmp += 2;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready2 got %b want 0", in_ready); end
        if (out_data !== w[0]) begin n_err++; $display("FAIL bp_hold2 got %h want %h", out_data, w[0]); end
        in_data = enc(w[2], k[2]);
        in_key = k[2];
        tick();
        n_cmp += 3;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready3 got %b want 0", in_ready); end
        if (out_data !== w[0]) begin n_err++; $display("FAIL bp_hold3 got %h want %h", out_data, w[0]); end
        if (out_key !== k[0]) begin n_err++; $display("FAIL bp_holdkey got %b want %b", out_key, k[0]); end
        out_ready = 1'b1;
        tick();
        n_cmp += 3;
        if (out_data !== w[1]) begin n_err++; $display("FAIL bp_second got %h want %h", out_data, w[1]); end
        if (out_key !== k[1]) begin n_err++; $display("FAIL bp_secondkey got %b want %b", out_key, k[1]); end
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_reopen got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp += 2;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_third_valid got %b want 1", out_valid); end
        if (out_data !== w[2]) begin n_err++; $display("FAIL bp_third got %h want %h", out_data, w[2]); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_streaming();
        logic [31:0] w [16];
        logic [1:0]  k;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w[i] = 32'h01020304 * (i + 1) ^ 32'h5A5A0000;
            k = 2'(i);
            in_valid = 1'b1;
            in_data = enc(w[i], k);
            in_key = k;
            tick();
            n_cmp += 3;
            if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %b want 1", i, out_valid); end
            if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d] got %b want 1", i, in_ready); end
            if (out_data !== w[i]) begin n_err++; $display("FAIL stream_data[%0d] got %h want %h", i, out_data, w[i]); end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_key = 2'b00;
        in_data = 32'h11111111;
        tick();
        in_data = 32'h22222222;
        tick();
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_pre_full got %b want 0", in_ready); end
        flush = 1'b1;
        in_data = 32'h33333333;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_cmp += 4;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b want 1", in_ready); end
        if (out_data !== 32'h0) begin n_err++; $display("FAIL flush_data got %h want 0", out_data); end
        if (out_key !== 2'b00) begin n_err++; $display("FAIL flush_key got %b want 00", out_key); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_dropped got %b want 0", out_valid); end
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h44332211;
        in_key = 2'b11;
        tick();
        in_valid = 1'b0;
        n_cmp += 2;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_after_valid got %b want 1", out_valid); end
        if (out_data !== 32'h22334411) begin n_err++; $display("FAIL flush_after_data got %h want 22334411", out_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hDEADBEEF;
        in_key = 2'b10;
        tick();
        reset = 1'b1;
        in_data = 32'hCAFEF00D;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        n_cmp += 4;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b want 1", in_ready); end
        if (out_data !== 32'h0) begin n_err++; $display("FAIL rstmid_data got %h want 0", out_data); end
        if (out_key !== 2'b00) begin n_err++; $display("FAIL rstmid_key got %b want 00", out_key); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_dropped got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_key_map();
        test_round_trip();
        test_backpressure();
        test_streaming();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
